// File: rtl/csa_accum_pkg.sv
// rtl/csa_accum_pkg.sv - shared types and default sizes for the carry-save accumulator
//
// Purpose : FSM state encoding and default parameter values used by
//           csa_accum_scheduler and its bench.
// Contents: state_t        - IDLE / ACCUM / RESOLVE / DONE
//           DEF_WIDTH      - operand width
//           DEF_MAX_OPS    - operands per batch before a forced resolve
//           DEF_RW, DEF_CW - derived result and count widths

package csa_accum_pkg;

    localparam int DEF_WIDTH   = 4;
    localparam int DEF_MAX_OPS = 16;
    localparam int DEF_RW      = DEF_WIDTH + $clog2(DEF_MAX_OPS);
    localparam int DEF_CW      = $clog2(DEF_MAX_OPS) + 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCUM   = 2'd1,
        ST_RESOLVE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/carry_save_logic_n.sv
// rtl/carry_save_logic_n.sv - N-bit 3:2 carry-save compressor
//
// Purpose : Reduces three N-bit addends to a sum word and a carry word whose
//           total equals a + b + c modulo 2^N.
// Ports   : i_a, i_b, i_c - addends
//           o_sum         - bitwise sum (xor of the three inputs)
//           o_carry       - majority bits shifted up one place, MSB carry dropped

module carry_save_logic_n #(
    parameter int N = 8
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic [N-1:0] i_c,
    output logic [N-1:0] o_sum,
    output logic [N-1:0] o_carry
);

    logic [N-1:0] w_maj;

    assign o_sum   = i_a ^ i_b ^ i_c;
    assign w_maj   = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
    // Dropping the top carry keeps the pair consistent modulo 2^N.
    assign o_carry = w_maj << 1;

endmodule

// File: rtl/csa_accum_scheduler.sv
// rtl/csa_accum_scheduler.sv - batch accumulator with carry-save partials and one resolve cycle
//
// Purpose : Accepts a stream of unsigned operands, keeps the running total in
//           carry-save form (S, C) so each operand costs only a 3:2 compress,
//           then resolves S + C once per batch and offers the result.
// Ports   : clk, rst_n          - clock, asynchronous active-low reset
//           clr                 - synchronous abort back to IDLE
//           in_valid/in_ready   - operand handshake; in_data operand, in_last batch end
//           out_valid/out_ready - result handshake
//           out_sum             - resolved batch sum (RW bits)
//           out_count           - operands in the batch (CW bits)

module csa_accum_scheduler
    import csa_accum_pkg::*;
#(
    parameter  int WIDTH   = DEF_WIDTH,
    parameter  int MAX_OPS = DEF_MAX_OPS,
    localparam int RW      = WIDTH + $clog2(MAX_OPS),
    localparam int CW      = $clog2(MAX_OPS) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RW-1:0]    out_sum,
    output logic [CW-1:0]    out_count
);

    state_t          r_state;
    state_t          w_next_state;

    logic [RW-1:0]   r_s;
    logic [RW-1:0]   r_c;
    logic [CW-1:0]   r_count;
    logic [RW-1:0]   r_out_sum;
    logic [CW-1:0]   r_out_count;

    logic            w_in_xfer;
    logic            w_out_xfer;
    logic            w_hit_max;
    logic [CW-1:0]   w_count_inc;
    logic [RW-1:0]   w_operand;
    logic [RW-1:0]   w_csa_sum;
    logic [RW-1:0]   w_csa_carry;

    assign in_ready    = (r_state == ST_IDLE) || (r_state == ST_ACCUM);
    assign out_valid   = (r_state == ST_DONE);
    assign out_sum     = r_out_sum;
    assign out_count   = r_out_count;

    assign w_in_xfer   = in_valid && in_ready;
    assign w_out_xfer  = out_valid && out_ready;
    assign w_operand   = RW'(in_data);
    assign w_count_inc = r_count + CW'(1);
    // The operand being accepted now is the one that fills the batch.
    assign w_hit_max   = (w_count_inc == CW'(MAX_OPS));

    carry_save_logic_n #(
        .N (RW)
    ) u_csa (
        .i_a     (r_s),
        .i_b     (r_c),
        .i_c     (w_operand),
        .o_sum   (w_csa_sum),
        .o_carry (w_csa_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (clr) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_in_xfer) begin
                        w_next_state = (in_last || (MAX_OPS == 1)) ? ST_RESOLVE : ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (w_in_xfer && (in_last || w_hit_max)) begin
                        w_next_state = ST_RESOLVE;
                    end
                end
                ST_RESOLVE: begin
                    w_next_state = ST_DONE;
                end
                ST_DONE: begin
                    if (w_out_xfer) begin
                        w_next_state = ST_IDLE;
                    end
                end
                default: begin
                    w_next_state = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s         <= '0;
            r_c         <= '0;
            r_count     <= '0;
            r_out_sum   <= '0;
            r_out_count <= '0;
        end else if (clr) begin
            r_s         <= '0;
            r_c         <= '0;
            r_count     <= '0;
            r_out_sum   <= '0;
            r_out_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_in_xfer) begin
                        r_s     <= w_operand;
                        r_c     <= '0;
                        r_count <= CW'(1);
                    end
                end
                ST_ACCUM: begin
                    if (w_in_xfer) begin
                        r_s     <= w_csa_sum;
                        r_c     <= w_csa_carry;
                        r_count <= w_count_inc;
                    end
                end
                ST_RESOLVE: begin
                    // Single carry-propagate add per batch.
                    r_out_sum   <= r_s + r_c;
                    r_out_count <= r_count;
                end
                ST_DONE: begin
                    if (w_out_xfer) begin
                        r_s     <= '0;
                        r_c     <= '0;
                        r_count <= '0;
                    end
                end
                default: begin
                    r_s     <= '0;
                    r_c     <= '0;
                    r_count <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csa_accum_scheduler.sv
// tb/tb_csa_accum_scheduler.sv - self-checking bench for csa_accum_scheduler

module tb_csa_accum_scheduler;

    localparam int WIDTH   = 4;
    localparam int MAX_OPS = 16;
    localparam int RW      = 8;
    localparam int CW      = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             clr;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [RW-1:0]    out_sum;
    logic [CW-1:0]    out_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    csa_accum_scheduler #(
        .WIDTH   (WIDTH),
        .MAX_OPS (MAX_OPS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count)
    );

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send_op(input logic [WIDTH-1:0] d, input logic l);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && waited < 50) begin
            cycle();
            waited++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_op_ready: in_ready=%0b after %0d cycles, required 1", in_ready, waited);
        end
        cycle();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b required 0", out_valid); end
        checks++; if (out_sum !== 8'd0)   begin errors++; $display("FAIL reset_out_sum: got %0d required 0", out_sum); end
        checks++; if (out_count !== 5'd0) begin errors++; $display("FAIL reset_out_count: got %0d required 0", out_count); end
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready: got %0b required 1", in_ready); end
        rst_n = 1'b1;
        cycle();
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL post_reset_in_ready: got %0b required 1", in_ready); end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        send_op(4'd3, 1'b0);
        send_op(4'd5, 1'b0);
        send_op(4'd7, 1'b1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_cycle1: got %0b required 0", out_valid); end
        checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL basic_ready_resolve: got %0b required 0", in_ready); end
        cycle();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid_cycle2: got %0b required 1", out_valid); end
        checks++; if (out_sum !== 8'd15)  begin errors++; $display("FAIL basic_sum: got %0d required 15", out_sum); end
        checks++; if (out_count !== 5'd3) begin errors++; $display("FAIL basic_count: got %0d required 3", out_count); end
        cycle();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_after: got %0b required 0", out_valid); end
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL basic_ready_after: got %0b required 1", in_ready); end
    endtask

    task automatic test_max_ops();
        out_ready = 1'b0;
        for (int i = 0; i < MAX_OPS; i++) send_op(4'd15, 1'b0);
        checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL max_ready_resolve: got %0b required 0", in_ready); end
        cycle();
        checks++; if (out_valid !== 1'b1)  begin errors++; $display("FAIL max_valid: got %0b required 1", out_valid); end
        checks++; if (out_sum !== 8'd240)  begin errors++; $display("FAIL max_sum: got %0d required 240", out_sum); end
        checks++; if (out_count !== 5'd16) begin errors++; $display("FAIL max_count: got %0d required 16", out_count); end
        checks++; if (in_ready !== 1'b0)   begin errors++; $display("FAIL max_ready_done: got %0b required 0", in_ready); end
        out_ready = 1'b1;
        cycle();
        checks++; if (in_ready !== 1'b1)   begin errors++; $display("FAIL max_ready_idle: got %0b required 1", in_ready); end
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send_op(4'd9, 1'b1);
        cycle();
        for (int i = 0; i < 5; i++) begin
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %0b required 1", i, out_valid); end
            checks++; if (out_sum !== 8'd9)   begin errors++; $display("FAIL bp_sum[%0d]: got %0d required 9", i, out_sum); end
            checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL bp_ready[%0d]: got %0b required 0", i, in_ready); end
            cycle();
        end
        out_ready = 1'b1;
        cycle();
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL bp_ready_release: got %0b required 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_release: got %0b required 0", out_valid); end
    endtask

    task automatic test_clr();
        out_ready = 1'b1;
        send_op(4'd6, 1'b0);
        clr = 1'b1;
        send_op(4'd8, 1'b0);
        clr = 1'b0;
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL clr_ready: got %0b required 1", in_ready); end
        checks++; if (out_sum !== 8'd0)   begin errors++; $display("FAIL clr_out_sum: got %0d required 0", out_sum); end
        send_op(4'd4, 1'b1);
        cycle();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL clr_valid: got %0b required 1", out_valid); end
        checks++; if (out_sum !== 8'd4)   begin errors++; $display("FAIL clr_sum: got %0d required 4", out_sum); end
        checks++; if (out_count !== 5'd1) begin errors++; $display("FAIL clr_count: got %0d required 1", out_count); end
        cycle();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        send_op(4'd2, 1'b0);
        send_op(4'd3, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL arst_accum_ready: got %0b required 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_accum_valid: got %0b required 0", out_valid); end
        #1 rst_n = 1'b1;
        cycle();
        send_op(4'd5, 1'b1);
        cycle();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL arst_pre_done_valid: got %0b required 1", out_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_done_valid: got %0b required 0", out_valid); end
        checks++; if (out_sum !== 8'd0)   begin errors++; $display("FAIL arst_done_sum: got %0d required 0", out_sum); end
        checks++; if (out_count !== 5'd0) begin errors++; $display("FAIL arst_done_count: got %0d required 0", out_count); end
        #1 rst_n = 1'b1;
        cycle();
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL arst_release_ready: got %0b required 1", in_ready); end
        out_ready = 1'b1;
        send_op(4'd1, 1'b0);
        send_op(4'd2, 1'b1);
        cycle();
        checks++; if (out_sum !== 8'd3)   begin errors++; $display("FAIL arst_new_sum: got %0d required 3", out_sum); end
        checks++; if (out_count !== 5'd2) begin errors++; $display("FAIL arst_new_count: got %0d required 2", out_count); end
        cycle();
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] op_d[$];
        logic             op_l[$];
        int               exp_sum[$];
        int               exp_cnt[$];
        int               total_ops;
        int               accepted;
        int               results;
        int               cyc;
        logic             took_in;
        logic             took_out;

        total_ops = 0;
        for (int b = 0; b < 1000; b++) begin
            int len;
            int s;
            logic use_last;
            len      = $urandom_range(1, MAX_OPS);
            use_last = (len < MAX_OPS) ? 1'b1 : 1'($urandom_range(0, 1));
            s        = 0;
            for (int k = 0; k < len; k++) begin
                logic [WIDTH-1:0] d;
                d = WIDTH'($urandom);
                s = s + int'(d);
                op_d.push_back(d);
                op_l.push_back((k == len - 1) ? use_last : 1'b0);
            end
            exp_sum.push_back(s % 256);
            exp_cnt.push_back(len);
            total_ops += len;
        end

        accepted = 0;
        results  = 0;
        cyc      = 0;
        while ((op_d.size() > 0 || exp_sum.size() > 0) && cyc < 80000) begin
            if (op_d.size() > 0 && $urandom_range(0, 3) != 0) begin
                in_valid = 1'b1;
                in_data  = op_d[0];
                in_last  = op_l[0];
            end else begin
                in_valid = 1'b0;
                in_data  = WIDTH'($urandom);
                in_last  = 1'($urandom_range(0, 1));
            end
            out_ready = ($urandom_range(0, 2) != 0);
            took_in   = in_valid && in_ready;
            took_out  = out_valid && out_ready;
            if (out_valid && in_ready) begin
                checks++; errors++;
                $display("FAIL rand_ready_in_done: in_ready=1 while out_valid=1, required 0");
            end
            if (took_out) begin
                if (exp_sum.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rand_extra_result: sum %0d with no batch expected", out_sum);
                end else begin
                    checks++;
                    if (int'(out_sum) != exp_sum[0]) begin
                        errors++;
                        $display("FAIL rand_sum[%0d]: got %0d required %0d", results, out_sum, exp_sum[0]);
                    end
                    checks++;
                    if (int'(out_count) != exp_cnt[0]) begin
                        errors++;
                        $display("FAIL rand_count[%0d]: got %0d required %0d", results, out_count, exp_cnt[0]);
                    end
                    void'(exp_sum.pop_front());
                    void'(exp_cnt.pop_front());
                    results++;
                end
            end
            cycle();
            cyc++;
            if (took_in) begin
                void'(op_d.pop_front());
                void'(op_l.pop_front());
                accepted++;
            end
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        checks++;
        if (op_d.size() != 0 || exp_sum.size() != 0) begin
            errors++;
            $display("FAIL rand_drain: %0d operands and %0d results left after %0d cycles, required 0 and 0",
                     op_d.size(), exp_sum.size(), cyc);
        end
        checks++;
        if (accepted != total_ops) begin
            errors++;
            $display("FAIL rand_operand_total: accepted %0d required %0d", accepted, total_ops);
        end
        checks++;
        if (results != 1000) begin
            errors++;
            $display("FAIL rand_result_total: got %0d required 1000", results);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max_ops();
        test_backpressure();
        test_clr();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
